// File: rtl/latch_ctrl_if.sv
// Handshake bundle between a word source, the stage latch and the frame consumer.
// The master side drives stimulus and latch feedback; the controller is the slave.
interface latch_ctrl_if #(
    parameter int DWIDTH = 8
);
    logic              en;
    logic              in_valid;
    logic [DWIDTH-1:0] in_data;
    logic              in_ready;
    logic              lat_start;
    logic [DWIDTH-1:0] lat_data;
    logic              lat_rst;
    logic              lat_done;
    logic              out_valid;
    logic              out_ready;
    logic              out_err;
    logic              err_underrun;
    logic              err_timeout;
    logic [15:0]       frame_cnt;

    modport master (
        output en, in_valid, in_data, lat_done, out_ready,
        input  in_ready, lat_start, lat_data, lat_rst, out_valid, out_err,
               err_underrun, err_timeout, frame_cnt
    );

    modport slave (
        input  en, in_valid, in_data, lat_done, out_ready,
        output in_ready, lat_start, lat_data, lat_rst, out_valid, out_err,
               err_underrun, err_timeout, frame_cnt
    );
endinterface

// File: rtl/latch_ctrl.sv
// Burst controller for a STAGE-deep shift latch: streams STAGE words in, waits for
// the latch update strobe (with timeout), then holds the frame until consumed.
//
// state | meaning
// IDLE  | waiting for en & in_valid to start a burst
// FILL  | presenting word cnt to the latch, STAGE cycles, never stalls
// WAIT  | waiting for lat_done, bounded by TMO cycles
// HOLD  | frame valid, waiting for out_ready
module latch_ctrl #(
    parameter int STAGE  = 8,
    parameter int DWIDTH = 8,
    parameter int TMO    = STAGE + 4
) (
    input  logic        clk,
    input  logic        rst_n,
    latch_ctrl_if.slave bus
);
    localparam int CW = $clog2(STAGE);
    localparam int TW = $clog2(TMO + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_e;

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic [TW-1:0]     tmr_q;
    logic              armed_q;
    logic              bad_q;
    logic              lat_start_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              out_err_q;
    logic              err_underrun_q;
    logic              err_timeout_q;
    logic [15:0]       frame_cnt_q;
    logic [DWIDTH-1:0] word_in;

    // armed_q keeps the first post-reset edge from launching a burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            tmr_q          <= '0;
            armed_q        <= 1'b0;
            bad_q          <= 1'b0;
            lat_start_q    <= 1'b0;
            in_ready_q     <= 1'b0;
            out_valid_q    <= 1'b0;
            out_err_q      <= 1'b0;
            err_underrun_q <= 1'b0;
            err_timeout_q  <= 1'b0;
            frame_cnt_q    <= '0;
        end else begin
            armed_q     <= 1'b1;
            lat_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (armed_q && bus.en && bus.in_valid) begin
                        state_q     <= FILL;
                        cnt_q       <= '0;
                        lat_start_q <= 1'b1;
                        in_ready_q  <= 1'b1;
                    end
                end
                FILL: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (!bus.in_valid) begin
                        err_underrun_q <= 1'b1;
                        bad_q          <= 1'b1;
                    end
                    if (cnt_q == CW'(STAGE - 1)) begin
                        state_q    <= WAIT;
                        in_ready_q <= 1'b0;
                        tmr_q      <= TW'(TMO - 1);
                    end
                end
                WAIT: begin
                    if (bus.lat_done) begin
                        state_q     <= HOLD;
                        out_valid_q <= 1'b1;
                        out_err_q   <= bad_q;
                    end else if (tmr_q == '0) begin
                        // Timed-out frame is dropped, so its bad mark goes with it.
                        state_q       <= IDLE;
                        err_timeout_q <= 1'b1;
                        bad_q         <= 1'b0;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        out_err_q   <= 1'b0;
                        bad_q       <= 1'b0;
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Data path is combinational so word k reaches the latch in FILL cycle k.
    assign word_in          = bus.in_data;
    assign bus.lat_data     = (in_ready_q && bus.in_valid) ? word_in : '0;
    assign bus.lat_rst      = ~rst_n;
    assign bus.in_ready     = in_ready_q;
    assign bus.lat_start    = lat_start_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_err      = out_err_q;
    assign bus.err_underrun = err_underrun_q;
    assign bus.err_timeout  = err_timeout_q;
    assign bus.frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_latch_ctrl.sv
// Directed bench for latch_ctrl: nominal burst, underrun, timeout, HOLD back-pressure,
// mid-burst reset and frame counter wrap.
module tb_latch_ctrl;
    localparam int STAGE = 8;
    localparam int TMO   = 12;

    logic        clk;
    logic        rst_n;
    int          checks;
    int          errors;
    logic [15:0] exp_fc;

    latch_ctrl_if #(.DWIDTH(8)) bus ();

    latch_ctrl #(.STAGE(STAGE), .DWIDTH(8), .TMO(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One burst starting from IDLE; bad_k<0 means no underrun word.
    task automatic do_burst(input int bad_k, input bit no_done, input int hold_n);
        logic [7:0] w;
        logic       exp_err;
        exp_err = (bad_k >= 0);
        bus.en       = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h11;
        #1;
        chk("idle_in_ready", bus.in_ready, 0);
        chk("idle_lat_start", bus.lat_start, 0);
        @(negedge clk);
        bus.en = 1'b0;
        for (int k = 0; k < STAGE; k++) begin
            w            = 8'((k + 1) * 17);
            bus.in_valid = (k != bad_k);
            bus.in_data  = w;
            #1;
            chk("fill_lat_start", bus.lat_start, (k == 0) ? 1 : 0);
            chk("fill_in_ready", bus.in_ready, 1);
            chk("fill_lat_data", bus.lat_data, (k == bad_k) ? 0 : w);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        #1;
        chk("wait_in_ready", bus.in_ready, 0);
        chk("wait_lat_start", bus.lat_start, 0);
        chk("wait_out_valid", bus.out_valid, 0);
        chk("err_underrun", bus.err_underrun, exp_err ? 1 : bus.err_underrun);
        if (no_done) begin
            for (int i = 1; i <= TMO; i++) begin
                chk("tmo_out_valid", bus.out_valid, 0);
                if (i == TMO) chk("tmo_not_yet", bus.err_timeout, 0);
                @(negedge clk);
            end
            #1;
            chk("tmo_err_timeout", bus.err_timeout, 1);
            chk("tmo_out_valid_end", bus.out_valid, 0);
            chk("tmo_frame_cnt", bus.frame_cnt, exp_fc);
            bus.lat_done = 1'b1;
            @(negedge clk);
            bus.lat_done = 1'b0;
            @(negedge clk);
            chk("stray_done_out_valid", bus.out_valid, 0);
            chk("stray_done_in_ready", bus.in_ready, 0);
            return;
        end
        @(negedge clk);
        bus.lat_done = 1'b1;
        #1;
        chk("c9_out_valid", bus.out_valid, 0);
        @(negedge clk);
        bus.lat_done = 1'b0;
        #1;
        chk("c10_out_valid", bus.out_valid, 1);
        chk("c10_out_err", bus.out_err, exp_err);
        for (int i = 0; i < hold_n; i++) begin
            bus.out_ready = 1'b0;
            @(negedge clk);
            chk("hold_out_valid", bus.out_valid, 1);
            chk("hold_out_err", bus.out_err, exp_err);
            chk("hold_lat_start", bus.lat_start, 0);
            chk("hold_frame_cnt", bus.frame_cnt, exp_fc);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        exp_fc = exp_fc + 16'd1;
        chk("done_out_valid", bus.out_valid, 0);
        chk("done_out_err", bus.out_err, 0);
        chk("done_frame_cnt", bus.frame_cnt, exp_fc);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        exp_fc        = 16'd0;
        rst_n         = 1'b0;
        bus.en        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.lat_done  = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_lat_start", bus.lat_start, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_lat_rst", bus.lat_rst, 1);
        chk("rst_lat_data", bus.lat_data, 0);
        chk("rst_frame_cnt", bus.frame_cnt, 0);
        chk("rst_err_underrun", bus.err_underrun, 0);
        chk("rst_err_timeout", bus.err_timeout, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("run_lat_rst", bus.lat_rst, 0);
        @(negedge clk);

        do_burst(-1, 1'b0, 0);
        chk("nominal_err_underrun", bus.err_underrun, 0);
        do_burst(3, 1'b0, 0);
        do_burst(-1, 1'b0, 5);
        chk("sticky_underrun", bus.err_underrun, 1);
        do_burst(-1, 1'b1, 0);
        do_burst(-1, 1'b0, 0);
        chk("sticky_timeout", bus.err_timeout, 1);

        bus.en       = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("en_low_in_ready", bus.in_ready, 0);
        chk("en_low_lat_start", bus.lat_start, 0);

        // Reset in the middle of FILL at cnt=4.
        bus.en      = 1'b1;
        bus.in_data = 8'h11;
        @(negedge clk);
        bus.en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.in_data = 8'((k + 1) * 17);
            @(negedge clk);
        end
        bus.in_data = 8'h55;
        #1;
        chk("pre_rst_in_ready", bus.in_ready, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", bus.in_ready, 0);
        chk("mid_rst_lat_data", bus.lat_data, 0);
        chk("mid_rst_lat_rst", bus.lat_rst, 1);
        chk("mid_rst_frame_cnt", bus.frame_cnt, 0);
        chk("mid_rst_err_underrun", bus.err_underrun, 0);
        chk("mid_rst_err_timeout", bus.err_timeout, 0);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        exp_fc = 16'd0;
        @(negedge clk);
        bus.en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_edge_lat_start", bus.lat_start, 0);
        chk("first_edge_in_ready", bus.in_ready, 0);
        bus.en       = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        do_burst(-1, 1'b0, 0);

        force dut.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt_q;
        @(negedge clk);
        exp_fc = 16'hFFFF;
        chk("preload_frame_cnt", bus.frame_cnt, exp_fc);
        do_burst(-1, 1'b0, 0);
        chk("wrap_frame_cnt", bus.frame_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/latch_ctrl.md
LATCH_CTRL -- requirements
Module: latch_ctrl

Interface
REQ-001 SHALL have parameter STAGE, default 8, number of words per burst/latch slots (>=2).
REQ-002 SHALL have parameter DWIDTH, default 8, data word width.
REQ-003 SHALL have parameter TMO, default STAGE+4, max cycles from last FILL cycle to lat_done before timeout.
REQ-004 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port en  input  1  permits starting a new burst.
REQ-007 SHALL have port in_valid  input  1  source word valid.
REQ-008 SHALL have port in_data  input  DWIDTH  source word.
REQ-009 SHALL have port in_ready  output  1  controller accepts the word this cycle.
REQ-010 SHALL have port lat_start  output  1  start pulse to the stage latch.
REQ-011 SHALL have port lat_data  output  DWIDTH  data to the stage latch.
REQ-012 SHALL have port lat_rst  output  1  active-high reset to the stage latch.
REQ-013 SHALL have port lat_done  input  1  latch output-update strobe (final shift stage).
REQ-014 SHALL have port out_valid  output  1  latched frame available.
REQ-015 SHALL have port out_ready  input  1  consumer accepts the frame.
REQ-016 SHALL have port out_err  output  1  frame contains an underrun word; qualified by out_valid.
REQ-017 SHALL have port err_underrun  output  1  sticky underrun flag.
REQ-018 SHALL have port err_timeout  output  1  sticky lat_done timeout flag.
REQ-019 SHALL have port frame_cnt  output  16  completed frames, modulo 2^16.

Function
REQ-020 FSM states SHALL be IDLE, FILL, WAIT, HOLD.
REQ-021 IDLE -> FILL on en=1 and in_valid=1; word counter cnt SHALL clear to 0.
REQ-022 lat_start SHALL be 1 exactly in the FILL cycle with cnt=0 and 0 in all other cycles (one-cycle pulse).
REQ-023 in_ready SHALL be 1 iff state=FILL; cnt SHALL increment every FILL cycle regardless of in_valid.
REQ-024 lat_data SHALL equal in_data when state=FILL and in_valid=1, and 0 otherwise; word k is presented in FILL cycle cnt=k.
REQ-025 FILL cycle with in_valid=0 (underrun): lat_data=0, err_underrun set (sticky), frame marked bad; burst SHALL NOT stall or abort.
REQ-026 FILL -> WAIT after the cycle with cnt=STAGE-1; FILL SHALL last exactly STAGE cycles.
REQ-027 WAIT -> HOLD on the edge after lat_done is sampled 1; nominal lat_done arrives 2 cycles after leaving FILL, giving out_valid STAGE+2 cycles after lat_start.
REQ-028 WAIT timeout: if lat_done is not seen within TMO cycles, err_timeout SHALL set (sticky) and FSM SHALL return to IDLE without out_valid or frame_cnt change.
REQ-029 HOLD: out_valid=1, out_err = frame-bad flag; held stable until out_ready=1.
REQ-030 HOLD with out_ready=1: frame_cnt increments (0xFFFF wraps to 0x0000), frame-bad clears, FSM -> IDLE; out_valid drops next cycle.
REQ-031 No new burst SHALL start before IDLE is reached; a back-to-back burst has at least one cycle with lat_start=0 between pulses.
REQ-032 en deasserted mid-burst SHALL NOT affect FILL/WAIT/HOLD; it only blocks the IDLE -> FILL transition.
REQ-033 lat_done=1 outside WAIT SHALL be ignored.
REQ-034 lat_rst SHALL equal NOT rst_n combinationally.

Reset
REQ-035 rst_n=0 SHALL asynchronously force IDLE, cnt=0, frame-bad=0, frame_cnt=0, err_underrun=0, err_timeout=0; lat_start, in_ready, out_valid, out_err=0, lat_data=0, lat_rst=1.
REQ-036 Reset asserted mid-FILL/WAIT/HOLD SHALL discard the frame with no frame_cnt change; first lat_start after release no earlier than the second clock edge after rst_n rises.
REQ-037 Sticky error flags SHALL clear only on reset.

Verification
REQ-038 STAGE=8, en=1, in_valid=1, in_data 0x11..0x88 consecutive, out_ready=1 -> one lat_start pulse, in_ready high 8 cycles, out_valid 10 cycles after lat_start, out_err=0, frame_cnt=1.
REQ-039 in_valid=0 during FILL cnt=3 -> lat_data=0x00 that cycle, err_underrun=1, out_err=1 with out_valid, FILL still 8 cycles.
REQ-040 lat_done tied 0 -> err_timeout=1 after TMO=12 WAIT cycles, FSM in IDLE, out_valid never 1, frame_cnt unchanged.
REQ-041 out_ready=0 for 5 cycles in HOLD -> out_valid/out_err stable 5 cycles, no lat_start, frame_cnt increments only on out_ready=1.
REQ-042 rst_n pulsed low during FILL cnt=4 -> all outputs at reset values immediately, frame_cnt=0, clean burst after release.
REQ-043 frame_cnt preloaded via 65535 frames (or forced) -> next completion wraps to 0x0000.
